// File: rtl/vregs_pkg.sv
// vregs_pkg: shared defaults, clear-engine state type and
// element slice helper for the masked vector register file.
package vregs_pkg;

   localparam int NREGS_D  = 16;
   localparam int NELEMS_D = 16;
   localparam int ELEM_W_D = 16;

   typedef enum logic {
      IDLE,
      CLEAR
   } clr_state_t;

   // Extract element idx from a default-sized vector.
   function automatic logic [ELEM_W_D-1:0] elem(
      input logic [NELEMS_D*ELEM_W_D-1:0] vec,
      input int unsigned                  idx
   );
      return vec[idx*ELEM_W_D +: ELEM_W_D];
   endfunction

endpackage

// File: rtl/vregs_clr_fsm.sv
// vregs_clr_fsm: sequential clear engine; walks every register
// once after reset or on request and gates writes meanwhile.
module vregs_clr_fsm
   import vregs_pkg::*;
#(
   parameter int   NREGS = NREGS_D,
   localparam int  AW    = $clog2(NREGS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clrReq,
   output logic          clrBusy,
   output logic          wReady,
   output logic          clrEn,
   output logic [AW-1:0] clrAddr
);

   clr_state_t    state;
   logic [AW-1:0] ptr;

   // Clear sequencing; busy/ready flags registered with the state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= CLEAR;
         ptr     <= '0;
         clrBusy <= 1'b1;
         wReady  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (clrReq) begin
                  state   <= CLEAR;
                  ptr     <= '0;
                  clrBusy <= 1'b1;
                  wReady  <= 1'b0;
               end
            end
            CLEAR: begin
               ptr <= ptr + 1'b1;
               if (ptr == AW'(NREGS - 1)) begin
                  state   <= IDLE;
                  clrBusy <= 1'b0;
                  wReady  <= 1'b1;
               end
            end
         endcase
      end
   end

   assign clrEn   = clrBusy;
   assign clrAddr = ptr;

endmodule

// File: rtl/vregs_mp.sv
// vregs_mp: masked vector register file with two vector read
// ports, one element read port, busy scoreboard and clear engine.
module vregs_mp
   import vregs_pkg::*;
#(
   parameter int  NREGS  = NREGS_D,
   parameter int  NELEMS = NELEMS_D,
   parameter int  ELEM_W = ELEM_W_D,
   localparam int AW     = $clog2(NREGS),
   localparam int IW     = $clog2(NELEMS),
   localparam int LEN_W  = IW + 1,
   localparam int VW     = NELEMS * ELEM_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [AW-1:0]     rAddr0_,
   input  logic [AW-1:0]     rAddr1_,
   output logic [VW-1:0]     rData0,
   output logic [VW-1:0]     rData1,
   output logic [LEN_W-1:0]  r_len0,
   output logic [LEN_W-1:0]  r_len1,
   input  logic [AW-1:0]     rAddrE,
   input  logic [IW-1:0]     rIdxE,
   output logic [ELEM_W-1:0] rDataE,
   input  logic              wEn,
   input  logic [AW-1:0]     wAddr,
   input  logic [NELEMS-1:0] wMask,
   input  logic              wLenEn,
   input  logic [LEN_W-1:0]  wLen,
   input  logic [VW-1:0]     wData,
   input  logic              wLast,
   output logic              wReady,
   input  logic              resEn,
   input  logic [AW-1:0]     resAddr,
   output logic [NREGS-1:0]  busy,
   input  logic              clrReq,
   output logic              clrBusy
);

   logic [VW-1:0]    data [NREGS];
   logic [LEN_W-1:0] len  [NREGS];
   logic [AW-1:0]    ra0;
   logic [AW-1:0]    ra1;
   logic             clrEn;
   logic [AW-1:0]    clrAddr;
   logic             wr_ok;
   logic             res_ok;
   logic [LEN_W-1:0] len_sat;

   assign wr_ok   = wEn & wReady;
   assign res_ok  = resEn & wReady;
   assign len_sat = (wLen > LEN_W'(NELEMS)) ? LEN_W'(NELEMS) : wLen;

   vregs_clr_fsm #(.NREGS(NREGS)) u_clr (
      .clk     (clk),
      .rst     (rst),
      .clrReq  (clrReq),
      .clrBusy (clrBusy),
      .wReady  (wReady),
      .clrEn   (clrEn),
      .clrAddr (clrAddr)
   );

   // Registered addresses for the full-vector read ports.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ra0 <= '0;
         ra1 <= '0;
      end else begin
         ra0 <= rAddr0_;
         ra1 <= rAddr1_;
      end
   end

   // Element storage: zeroed by the clear engine, else masked write.
   always_ff @(posedge clk) begin
      if (clrEn) begin
         data[clrAddr] <= '0;
      end else if (wr_ok) begin
         for (int i = 0; i < NELEMS; i++) begin
            if (wMask[i])
               data[wAddr][i*ELEM_W +: ELEM_W] <= wData[i*ELEM_W +: ELEM_W];
         end
      end
   end

   // Vector lengths, saturated at NELEMS on write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < NREGS; r++)
            len[r] <= '0;
      end else if (clrEn) begin
         len[clrAddr] <= '0;
      end else if (wr_ok && wLenEn) begin
         len[wAddr] <= len_sat;
      end
   end

   // Scoreboard: a same-cycle reserve overrides the release.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy <= '0;
      end else begin
         if (clrEn)
            busy[clrAddr] <= 1'b0;
         if (wr_ok && wLast)
            busy[wAddr] <= 1'b0;
         if (res_ok)
            busy[resAddr] <= 1'b1;
      end
   end

   assign rData0 = data[ra0];
   assign rData1 = data[ra1];
   assign r_len0 = len[ra0];
   assign r_len1 = len[ra1];
   assign rDataE = data[rAddrE][rIdxE*ELEM_W +: ELEM_W];

endmodule
